simplerisc_instr_encoder: RTL and testbench

Streaming SimpleRISC instruction encoder and program loader: the inverse of the instruction decoder. It accepts field-level instruction requests over a valid/ready handshake, packs them into 32-bit SimpleRISC words, and emits them with sequential instruction-memory addresses through a 2-entry output buffer. It sits between the test/boot program source and instruction memory.

---
 rtl/simplerisc_pkg.sv | 49 ++++
 rtl/simplerisc_enc_fifo.sv | 58 +++++
 rtl/simplerisc_instr_encoder.sv | 147 ++++++++++++++
 tb/tb_simplerisc_instr_encoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/simplerisc_pkg.sv
// rtl/simplerisc_pkg.sv - SimpleRISC opcodes, field positions, error codes and encoder FSM states
package simplerisc_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_LSL  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_NOP  = 5'd13;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BGT  = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;

  localparam int FLD_OP_LSB  = 27;
  localparam int FLD_I_BIT   = 26;
  localparam int FLD_RD_LSB  = 22;
  localparam int FLD_RS1_LSB = 18;
  localparam int FLD_RS2_LSB = 14;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OPCODE   = 2'b01;
  localparam logic [1:0] ERR_MODIFIER = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic f_is_alu_form(input logic [4:0] op);
    return (op <= OP_ASR) || (op == OP_LD) || (op == OP_ST);
  endfunction

  function automatic logic f_op_legal(input logic [4:0] op);
    return op <= OP_RET;
  endfunction

endpackage

// File: rtl/simplerisc_enc_fifo.sv
// rtl/simplerisc_enc_fifo.sv - 2-entry output buffer with a registered head entry
module simplerisc_enc_fifo #(
  parameter int W = 42
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_valid,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  // Head is always entry 0 so the output port is driven straight from a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_wdata;
          else                 r_tail <= i_wdata;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_wdata;
          end else begin
            r_head <= r_tail;
            r_tail <= i_wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rdata = r_head;
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/simplerisc_instr_encoder.sv
// rtl/simplerisc_instr_encoder.sv - streaming SimpleRISC encoder/program loader
// Optional modifier range check: SIMPLERISC_ENC_RANGE_CHECK_EN
module simplerisc_instr_encoder
  import simplerisc_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              last,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic              in_imm_sel,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic [17:0]       in_imm,
  input  logic [26:0]       in_offset,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_instr,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);

  logic [1:0]         r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W:0]    r_word_count;
  logic               r_err_valid;
  logic [1:0]         r_err_code;

  logic               w_accept;
  logic               w_op_ok;
  logic               w_mod_ok;
  logic               w_legal;
  logic               w_enq;
  logic               w_deq;
  logic [31:0]        w_enc;
  logic [ADDR_W+31:0] w_fifo_rdata;
  logic               w_fifo_valid;
  logic [1:0]         w_fifo_count;

  function automatic logic [31:0] f_encode(
    input logic [4:0]  op,
    input logic        imm_sel,
    input logic [3:0]  rd,
    input logic [3:0]  rs1,
    input logic [3:0]  rs2,
    input logic [17:0] imm,
    input logic [26:0] offset
  );
    logic [31:0] w;
    w = '0;
    w[FLD_OP_LSB +: 5] = op;
    if (f_is_alu_form(op)) begin
      w[FLD_I_BIT]          = imm_sel;
      w[FLD_RD_LSB +: 4]    = rd;
      w[FLD_RS1_LSB +: 4]   = rs1;
      if (imm_sel) w[17:0]  = imm;
      else         w[FLD_RS2_LSB +: 4] = rs2;
    end else if (op >= OP_BEQ && op <= OP_CALL) begin
      w[26:0] = offset;
    end
    return w;
  endfunction

  assign in_ready = (r_state == ST_RUN) && (w_fifo_count != 2'd2);
  assign w_accept = in_valid && in_ready;
  assign w_op_ok  = f_op_legal(in_opcode);

`ifdef SIMPLERISC_ENC_RANGE_CHECK_EN
  assign w_mod_ok = !(f_is_alu_form(in_opcode) && in_imm_sel && (in_imm[17:16] == 2'b11));
`else
  assign w_mod_ok = 1'b1;
`endif

  assign w_legal = w_op_ok && w_mod_ok;
  assign w_enq   = w_accept && w_legal;
  assign w_deq   = w_fifo_valid && out_ready;
  assign w_enc   = f_encode(in_opcode, in_imm_sel, in_rd, in_rs1, in_rs2, in_imm, in_offset);

  simplerisc_enc_fifo #(
    .W(ADDR_W + 32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_enq),
    .i_wdata ({r_addr, w_enc}),
    .i_pop   (out_ready),
    .o_rdata (w_fifo_rdata),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start) r_state <= ST_RUN;
        // A rejected final request still closes the program.
        ST_RUN:   if (w_accept && last) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_fifo_count == 2'd0) r_state <= ST_DONE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_word_count <= '0;
    end else begin
      if (r_state == ST_IDLE && start) r_addr <= base_addr;
      else if (w_enq)                  r_addr <= r_addr + ADDR_W'(1);

      if (r_state == ST_IDLE && start) r_word_count <= '0;
      else if (w_deq)                  r_word_count <= r_word_count + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_err_valid <= w_accept && !w_legal;
      if (w_accept && !w_legal) r_err_code <= w_op_ok ? ERR_MODIFIER : ERR_OPCODE;
      else                      r_err_code <= ERR_NONE;
    end
  end

  assign out_valid  = w_fifo_valid;
  assign out_addr   = w_fifo_rdata[ADDR_W+31:32];
  assign out_instr  = w_fifo_rdata[31:0];
  assign err_valid  = r_err_valid;
  assign err_code   = r_err_code;
  assign done       = (r_state == ST_DONE);
  assign word_count = r_word_count;

endmodule

// File: tb/tb_simplerisc_instr_encoder.sv
// tb/tb_simplerisc_instr_encoder.sv - scoreboard bench for simplerisc_instr_encoder
module tb_simplerisc_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic        last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_opcode = '0;
  logic        in_imm_sel = 1'b0;
  logic [3:0]  in_rd = '0;
  logic [3:0]  in_rs1 = '0;
  logic [3:0]  in_rs2 = '0;
  logic [17:0] in_imm = '0;
  logic [26:0] in_offset = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  out_addr;
  logic [31:0] out_instr;
  logic        err_valid;
  logic [1:0]  err_code;
  logic        done;
  logic [10:0] word_count;

  int checks = 0;
  int errors = 0;
  logic [41:0] sb_q[$];
  logic [1:0]  err_q[$];
  logic [9:0]  exp_addr = '0;

  simplerisc_instr_encoder #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .last(last),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_imm_sel(in_imm_sel), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_offset(in_offset), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_instr(out_instr),
    .err_valid(err_valid), .err_code(err_code), .done(done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor: every word handshake is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got addr %h instr %h expected nothing", out_addr, out_instr);
      end else begin
        logic [41:0] e;
        e = sb_q.pop_front();
        check("word", {out_addr, out_instr}, e);
      end
    end
    if (!rst && err_valid) begin
      if (err_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_err: got code %0d expected no error", err_code);
      end else begin
        logic [1:0] ec;
        ec = err_q.pop_front();
        check("err_code", {40'd0, err_code}, {40'd0, ec});
      end
    end
  end

  task automatic do_start(input logic [9:0] base);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = base;
  endtask

  task automatic send(input logic [4:0] op, input logic isel, input logic [3:0] rd,
                      input logic [3:0] rs1, input logic [3:0] rs2, input logic [17:0] imm,
                      input logic [26:0] off, input logic lst,
                      input logic [31:0] exp_w, input logic [1:0] exp_err);
    int n;
    in_opcode = op; in_imm_sel = isel; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_offset = off; last = lst; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1 within 200 cycles");
    end else if (exp_err == 2'b00) begin
      sb_q.push_back({exp_addr, exp_w});
      exp_addr = exp_addr + 10'd1;
    end else begin
      err_q.push_back(exp_err);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; last = 1'b0;
  endtask

  task automatic wait_done(input logic [10:0] exp_wc);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {41'd0, done}, 42'd1);
    check("word_count", {31'd0, word_count}, {31'd0, exp_wc});
    @(negedge clk);
    check("done_pulse_end", {41'd0, done}, 42'd0);
    check("sb_empty", 42'(sb_q.size() + err_q.size()), 42'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},  {41'd0, in_ready},  42'd0);
    check({tag, "_out_valid"}, {41'd0, out_valid}, 42'd0);
    check({tag, "_out_word"},  {out_addr, out_instr}, 42'd0);
    check({tag, "_err"},       {39'd0, err_valid, err_code}, 42'd0);
    check({tag, "_done"},      {41'd0, done}, 42'd0);
    check({tag, "_wc"},        {31'd0, word_count}, 42'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    // add r1,r2,r3 as a single-instruction program
    out_ready = 1'b1;
    do_start(10'h010);
    send(5'd0, 1'b0, 4'd1, 4'd2, 4'd3, 18'h0, 27'h0, 1'b1, 32'h0048C000, 2'b00);
    wait_done(11'd1);

    // mov / b / nop / ret; a start pulse while running must be ignored
    do_start(10'h020);
    send(5'd9, 1'b1, 4'd5, 4'd0, 4'd0, 18'h01234, 27'h0, 1'b0, 32'h4D401234, 2'b00);
    @(posedge clk); #1 start = 1'b1; base_addr = 10'h200;
    @(posedge clk); #1 start = 1'b0;
    send(5'd18, 1'b0, 4'd7, 4'd7, 4'd7, 18'h3FFFF, 27'h0000040, 1'b0, 32'h90000040, 2'b00);
    send(5'd13, 1'b1, 4'd9, 4'd9, 4'd9, 18'h3FFFF, 27'h7FFFFFF, 1'b0, 32'h68000000, 2'b00);
    send(5'd20, 1'b0, 4'd15, 4'd15, 4'd0, 18'h0, 27'h0, 1'b1, 32'hA0000000, 2'b00);
    wait_done(11'd4);

    // illegal opcodes: address not consumed, rejected last still ends program
    do_start(10'h040);
    send(5'b11000, 1'b0, 4'd1, 4'd1, 4'd1, 18'h0, 27'h0, 1'b0, 32'h0, 2'b01);
    send(5'd1, 1'b1, 4'd2, 4'd3, 4'd0, 18'h00005, 27'h0, 1'b0, 32'h0C8C0005, 2'b00);
    send(5'b10101, 1'b0, 4'd0, 4'd0, 4'd0, 18'h0, 27'h0, 1'b1, 32'h0, 2'b01);
    wait_done(11'd1);

    // backpressure with address wrap at 0x3FF
    out_ready = 1'b0;
    do_start(10'h3FF);
    send(5'd2, 1'b0, 4'd1, 4'd1, 4'd1, 18'h0, 27'h0, 1'b0, 32'h10444000, 2'b00);
    send(5'd19, 1'b0, 4'd0, 4'd0, 4'd0, 18'h0, 27'h7FFFFFF, 1'b0, 32'h9FFFFFFF, 2'b00);
    @(negedge clk);
    check("full_in_ready", {41'd0, in_ready}, 42'd0);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", {41'd0, out_valid}, 42'd1);
      check("stall_word", {out_addr, out_instr}, {10'h3FF, 32'h10444000});
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send(5'd13, 1'b0, 4'd0, 4'd0, 4'd0, 18'h0, 27'h0, 1'b1, 32'h68000000, 2'b00);
    wait_done(11'd3);

    // ld with modifier 11 in immediate form, then st register form
    do_start(10'h100);
`ifdef SIMPLERISC_ENC_RANGE_CHECK_EN
    send(5'd14, 1'b1, 4'd1, 4'd2, 4'd0, 18'h30010, 27'h0, 1'b0, 32'h0, 2'b10);
    send(5'd15, 1'b0, 4'd7, 4'd8, 4'd0, 18'h0, 27'h0, 1'b1, 32'h79E00000, 2'b00);
    wait_done(11'd1);
`else
    send(5'd14, 1'b1, 4'd1, 4'd2, 4'd0, 18'h30010, 27'h0, 1'b0, 32'h744B0010, 2'b00);
    send(5'd15, 1'b0, 4'd7, 4'd8, 4'd0, 18'h0, 27'h0, 1'b1, 32'h79E00000, 2'b00);
    wait_done(11'd2);
`endif

    // reset while draining discards the buffered word
    out_ready = 1'b0;
    do_start(10'h080);
    send(5'd13, 1'b0, 4'd0, 4'd0, 4'd0, 18'h0, 27'h0, 1'b1, 32'h68000000, 2'b00);
    @(negedge clk);
    check("drain_valid", {41'd0, out_valid}, 42'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check_reset_state("midrst");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {41'd0, in_ready}, 42'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
